arcade_input_merge: RTL and testbench

Parametrised player-input front end for arcade cores on the multicore board. It merges debounced DB9 joystick pins and board buttons with keyboard-mapped joystick bits for N players. It produces fixed-width coin pulses and handles a start1+start2 hotkey that cycles the scanline mode. It sits between the raw board pins / kbd_joystick output and the game core / video scaler, and replaces per-core ad-hoc OR logic and single-button debounce.

---
 rtl/arcade_input_merge_if.sv | 39 +++
 rtl/arcade_input_merge.sv | 195 +++++++++++++++++++
 tb/tb_arcade_input_merge.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_merge_if.sv
// -----------------------------------------------------------------------------
// arcade_input_merge_if
// Player-input bundle between the board pins / keyboard mapper and the game
// core. The master side drives raw pins and keyboard bits; the slave side
// (arcade_input_merge) returns merged joystick, start, coin and scanline state.
//   db9_n_i     PLAYERS*JW      raw DB9 pins, active-low, asynchronous
//   kbd_i       PLAYERS*(JW+2)  keyboard bits per player {coin, start, joy}
//   start_n_i   PLAYERS         board start buttons, active-low, asynchronous
//   coin_n_i    PLAYERS         board coin buttons, active-low, asynchronous
//   joy_o       PLAYERS*JW      merged joystick, active-high
//   start_o     PLAYERS         merged start, active-high
//   coin_o      PLAYERS         fixed-length coin pulses, active-high
//   scanlines_o 2               scanline mode 0..3
//   hotkey_o    1               start1+start2 hotkey armed
// -----------------------------------------------------------------------------
interface arcade_input_merge_if #(
  parameter int PLAYERS = 2,
  parameter int JW      = 6
);
  logic [PLAYERS*JW-1:0]     db9_n_i;
  logic [PLAYERS*(JW+2)-1:0] kbd_i;
  logic [PLAYERS-1:0]        start_n_i;
  logic [PLAYERS-1:0]        coin_n_i;
  logic [PLAYERS*JW-1:0]     joy_o;
  logic [PLAYERS-1:0]        start_o;
  logic [PLAYERS-1:0]        coin_o;
  logic [1:0]                scanlines_o;
  logic                      hotkey_o;

  modport master (
    output db9_n_i, kbd_i, start_n_i, coin_n_i,
    input  joy_o, start_o, coin_o, scanlines_o, hotkey_o
  );

  modport slave (
    input  db9_n_i, kbd_i, start_n_i, coin_n_i,
    output joy_o, start_o, coin_o, scanlines_o, hotkey_o
  );
endinterface

// File: rtl/arcade_input_merge.sv
// -----------------------------------------------------------------------------
// arcade_input_merge
// Player-input front end: synchronises and debounces the asynchronous board
// pins, ORs them with the already-clean keyboard bits, turns coin presses into
// fixed-length pulses and runs the start1+start2 scanline hotkey.
//   clk_sys  system clock
//   reset    synchronous, active-high reset
//   ce       debounce / coin-pulse timebase enable (one clk_sys cycle wide)
//   bus      arcade_input_merge_if slave modport (pins in, merged state out)
// -----------------------------------------------------------------------------
module arcade_input_merge #(
  parameter int PLAYERS  = 2,
  parameter int JW       = 6,
  parameter int DEB_BITS = 10,
  parameter int COIN_LEN = 8
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce,
  arcade_input_merge_if.slave  bus
);

  localparam int NJ = PLAYERS * JW;
  localparam int NB = NJ + 2 * PLAYERS;
  localparam int KW = JW + 2;
  // The counter value seen on the final ce tick; the stable value flips on
  // that tick, giving 2^DEB_BITS-1 ticks in total.
  localparam logic [DEB_BITS-1:0] DEB_LAST  = DEB_BITS'((1 << DEB_BITS) - 2);
  localparam logic [DEB_BITS-1:0] DEB_ONE   = DEB_BITS'(1);
  localparam logic [DEB_BITS-1:0] DEB_ZERO  = DEB_BITS'(0);
  localparam logic [7:0]          COIN_INIT = 8'(COIN_LEN);

  typedef enum logic [0:0] {
    HK_IDLE  = 1'b0,
    HK_ARMED = 1'b1
  } hk_state_e;

  // Raw pins packed as {coin_n, start_n, db9_n}
  logic [NB-1:0]       raw_s;
  logic [NB-1:0]       sync1_r;
  logic [NB-1:0]       sync2_r;
  logic [NB-1:0]       stable_r;
  logic [DEB_BITS-1:0] cnt_r [NB];

  logic [NJ-1:0]       kbd_joy_s;
  logic [PLAYERS-1:0]  kbd_start_s;
  logic [PLAYERS-1:0]  kbd_coin_s;
  logic [NJ-1:0]       joy_next_s;
  logic [PLAYERS-1:0]  start_req_next_s;
  logic [PLAYERS-1:0]  coin_req_next_s;
  logic [PLAYERS-1:0]  start_stable_s;
  logic [PLAYERS-1:0]  coin_stable_s;

  logic [NJ-1:0]       joy_r;
  logic [PLAYERS-1:0]  start_o_r;
  logic [PLAYERS-1:0]  coin_req_r;
  logic [PLAYERS-1:0]  coin_o_r;
  logic [7:0]          coin_t_r [PLAYERS];
  logic [1:0]          scan_r;
  logic                hotkey_r;

  hk_state_e           hk_state_r;
  hk_state_e           hk_next_s;
  logic                scan_inc_s;
  logic                both_pressed_s;
  logic                both_released_s;

  assign raw_s          = {bus.coin_n_i, bus.start_n_i, bus.db9_n_i};
  assign start_stable_s = stable_r[NJ +: PLAYERS];
  assign coin_stable_s  = stable_r[NJ + PLAYERS +: PLAYERS];

  // Two-flop synchroniser; resets to all-released
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_r <= {NB{1'b1}};
      sync2_r <= {NB{1'b1}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce: stable value flips after 2^DEB_BITS-1 ce ticks of disagreement
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      stable_r <= {NB{1'b1}};
      for (int i = 0; i < NB; i++) cnt_r[i] <= DEB_ZERO;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          cnt_r[i] <= DEB_ZERO;
        end else if (ce) begin
          if (cnt_r[i] == DEB_LAST) begin
            stable_r[i] <= sync2_r[i];
            cnt_r[i]    <= DEB_ZERO;
          end else begin
            cnt_r[i] <= cnt_r[i] + DEB_ONE;
          end
        end
      end
    end
  end

  // Unpack keyboard bits and form the merged request vectors
  always_comb begin
    kbd_joy_s   = {NJ{1'b0}};
    kbd_start_s = {PLAYERS{1'b0}};
    kbd_coin_s  = {PLAYERS{1'b0}};
    for (int p = 0; p < PLAYERS; p++) begin
      kbd_joy_s[p*JW +: JW] = bus.kbd_i[p*KW +: JW];
      kbd_start_s[p]        = bus.kbd_i[p*KW + JW];
      kbd_coin_s[p]         = bus.kbd_i[p*KW + JW + 1];
    end
    joy_next_s       = ~stable_r[NJ-1:0] | kbd_joy_s;
    start_req_next_s = ~start_stable_s | kbd_start_s;
    coin_req_next_s  = ~coin_stable_s | kbd_coin_s;
  end

  // Hotkey only looks at the debounced board starts of players 0 and 1
  generate
    if (PLAYERS >= 2) begin : g_hk
      assign both_pressed_s  = ~start_stable_s[0] & ~start_stable_s[1];
      assign both_released_s =  start_stable_s[0] &  start_stable_s[1];
    end else begin : g_no_hk
      assign both_pressed_s  = 1'b0;
      assign both_released_s = 1'b0;
    end
  endgenerate

  // Hotkey next-state: arm on both pressed, one scanline step per arming
  always_comb begin
    hk_next_s  = hk_state_r;
    scan_inc_s = 1'b0;
    case (hk_state_r)
      HK_IDLE: begin
        if (both_pressed_s) hk_next_s = HK_ARMED;
        else                hk_next_s = HK_IDLE;
      end
      HK_ARMED: begin
        if (both_released_s) begin
          hk_next_s  = HK_IDLE;
          scan_inc_s = 1'b1;
        end else begin
          hk_next_s = HK_ARMED;
        end
      end
      default: hk_next_s = HK_IDLE;
    endcase
  end

  // Output registers, hotkey state and coin pulse timers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joy_r      <= {NJ{1'b0}};
      start_o_r  <= {PLAYERS{1'b0}};
      coin_req_r <= {PLAYERS{1'b0}};
      coin_o_r   <= {PLAYERS{1'b0}};
      for (int p = 0; p < PLAYERS; p++) coin_t_r[p] <= 8'd0;
      scan_r     <= 2'd0;
      hotkey_r   <= 1'b0;
      hk_state_r <= HK_IDLE;
    end else begin
      joy_r      <= joy_next_s;
      coin_req_r <= coin_req_next_s;
      hk_state_r <= hk_next_s;
      // Mask with the next state so start_o and hotkey_o change on the same edge
      hotkey_r   <= (hk_next_s == HK_ARMED);
      start_o_r  <= start_req_next_s & ~{PLAYERS{hk_next_s == HK_ARMED}};
      if (scan_inc_s) scan_r <= scan_r + 2'd1;
      for (int p = 0; p < PLAYERS; p++) begin
        if (coin_o_r[p]) begin
          // Active pulse: count down, ignore any new edge
          if (ce) begin
            if (coin_t_r[p] == 8'd1) begin
              coin_o_r[p] <= 1'b0;
              coin_t_r[p] <= 8'd0;
            end else begin
              coin_t_r[p] <= coin_t_r[p] - 8'd1;
            end
          end
        end else if (coin_req_next_s[p] && !coin_req_r[p]) begin
          coin_o_r[p] <= 1'b1;
          coin_t_r[p] <= COIN_INIT;
        end
      end
    end
  end

  assign bus.joy_o       = joy_r;
  assign bus.start_o     = start_o_r;
  assign bus.coin_o      = coin_o_r;
  assign bus.scanlines_o = scan_r;
  assign bus.hotkey_o    = hotkey_r;

endmodule

// File: tb/tb_arcade_input_merge.sv
// -----------------------------------------------------------------------------
// tb_arcade_input_merge
// Directed bench for arcade_input_merge with PLAYERS=2, JW=6, DEB_BITS=4,
// COIN_LEN=8. Inputs change 1 time unit after each rising edge and outputs are
// observed at the same point.
// -----------------------------------------------------------------------------
module tb_arcade_input_merge;

  localparam int PLAYERS = 2;
  localparam int JW      = 6;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ce      = 1'b0;

  int tests   = 0;
  int fails   = 0;
  int ce_div  = 1;
  int phase   = 0;
  int rises0  = 0;
  int rises1  = 0;
  int ce_hi0  = 0;
  int ce_hi1  = 0;
  int max_joy = 0;

  arcade_input_merge_if #(.PLAYERS(PLAYERS), .JW(JW)) bus ();

  arcade_input_merge #(
    .PLAYERS(PLAYERS), .JW(JW), .DEB_BITS(4), .COIN_LEN(8)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ce for the coming edge, then record coin pulse activity.
  task automatic tick();
    logic [1:0] pre_coin;
    logic       pre_ce;
    ce       = (ce_div == 1) ? 1'b1 : (phase == 0);
    phase    = (phase + 1) % ce_div;
    pre_coin = bus.coin_o;
    pre_ce   = ce;
    @(posedge clk_sys);
    #1;
    if (pre_coin[0] && pre_ce) ce_hi0++;
    if (pre_coin[1] && pre_ce) ce_hi1++;
    if (bus.coin_o[0] && !pre_coin[0]) rises0++;
    if (bus.coin_o[1] && !pre_coin[1]) rises1++;
    if (bus.joy_o[0]) max_joy = 1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    rises0 = 0; rises1 = 0; ce_hi0 = 0; ce_hi1 = 0; max_joy = 0;
  endtask

  // One full hotkey arming: start0, start1 200 cycles later, release both.
  task automatic hotkey_cycle(input logic [1:0] scan_before);
    bus.start_n_i[0] = 1'b0;
    ticks(200);
    chk("hk_start0_alone", {30'd0, bus.start_o}, 32'h1);
    chk("hk_idle_hotkey", {31'd0, bus.hotkey_o}, 32'h0);
    bus.start_n_i[1] = 1'b0;
    ticks(40);
    chk("hk_armed_hotkey", {31'd0, bus.hotkey_o}, 32'h1);
    chk("hk_armed_start", {30'd0, bus.start_o}, 32'h0);
    chk("hk_armed_scan", {30'd0, bus.scanlines_o}, {30'd0, scan_before});
    bus.start_n_i = 2'b11;
    ticks(40);
    chk("hk_released_hotkey", {31'd0, bus.hotkey_o}, 32'h0);
    chk("hk_released_scan", {30'd0, bus.scanlines_o}, {30'd0, scan_before + 2'd1});
  endtask

  initial begin
    bus.db9_n_i   = 12'hfff;
    bus.kbd_i     = 16'h0000;
    bus.start_n_i = 2'b11;
    bus.coin_n_i  = 2'b11;

    // Reset state
    ticks(3);
    chk("rst_joy", {20'd0, bus.joy_o}, 32'h0);
    chk("rst_start", {30'd0, bus.start_o}, 32'h0);
    chk("rst_coin", {30'd0, bus.coin_o}, 32'h0);
    chk("rst_scan", {30'd0, bus.scanlines_o}, 32'h0);
    chk("rst_hotkey", {31'd0, bus.hotkey_o}, 32'h0);
    reset = 1'b0;
    ticks(2);

    // Debounce: 2 sync + 15 ce ticks + 1 merge register = edge 18
    bus.db9_n_i[0] = 1'b0;
    ticks(17);
    chk("deb_edge17", {31'd0, bus.joy_o[0]}, 32'h0);
    tick();
    chk("deb_edge18", {20'd0, bus.joy_o}, 32'h1);
    bus.db9_n_i[0] = 1'b1;
    ticks(20);
    chk("deb_release", {20'd0, bus.joy_o}, 32'h0);
    clear_counts();
    bus.db9_n_i[0] = 1'b0;
    ticks(10);
    bus.db9_n_i[0] = 1'b1;
    ticks(30);
    chk("deb_glitch", max_joy, 0);

    // Keyboard merge: player 1 fire1 is kbd bit 12, joy bit 10
    bus.kbd_i[12] = 1'b1;
    tick();
    chk("kbd_fire1", {20'd0, bus.joy_o}, 32'h400);
    bus.kbd_i[12] = 1'b0;
    tick();
    chk("kbd_fire1_rel", {20'd0, bus.joy_o}, 32'h0);
    bus.kbd_i[14] = 1'b1;
    tick();
    chk("kbd_start1", {30'd0, bus.start_o}, 32'h2);
    bus.kbd_i[14] = 1'b0;
    tick();
    chk("kbd_start1_rel", {30'd0, bus.start_o}, 32'h0);

    // Coin from board button, ce every 4th cycle, held 500 cycles
    ce_div = 4;
    phase  = 0;
    clear_counts();
    bus.coin_n_i[0] = 1'b0;
    ticks(500);
    bus.coin_n_i[0] = 1'b1;
    ticks(100);
    chk("coin_hold_pulses", rises0, 1);
    chk("coin_hold_len", ce_hi0, 8);
    chk("coin_hold_other", rises1, 0);
    chk("coin_idle", {30'd0, bus.coin_o}, 32'h0);
    clear_counts();
    bus.coin_n_i[0] = 1'b0;
    ticks(150);
    bus.coin_n_i[0] = 1'b1;
    ticks(100);
    chk("coin_second_pulses", rises0, 1);
    chk("coin_second_len", ce_hi0, 8);

    // Keyboard coin toggling during an active pulse
    clear_counts();
    bus.kbd_i[7] = 1'b1;
    tick();
    chk("coin_kbd_rise", {30'd0, bus.coin_o}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      ticks(3);
      bus.kbd_i[7] = 1'b0;
      ticks(2);
      bus.kbd_i[7] = 1'b1;
    end
    bus.kbd_i[7] = 1'b0;
    ticks(60);
    chk("coin_retrig_pulses", rises0, 1);
    chk("coin_retrig_len", ce_hi0, 8);

    // Hotkey: four armings wrap scanlines 0->1->2->3->0
    ce_div = 1;
    for (int r = 0; r < 4; r++) hotkey_cycle(2'(r));
    chk("hk_wrap", {30'd0, bus.scanlines_o}, 32'h0);

    // Keyboard start is masked while armed
    bus.start_n_i = 2'b00;
    ticks(40);
    bus.kbd_i[6] = 1'b1;
    tick();
    chk("hk_kbd_start_masked", {30'd0, bus.start_o}, 32'h0);
    bus.kbd_i[6] = 1'b0;
    bus.start_n_i = 2'b11;
    ticks(40);
    chk("hk_after_kbd_scan", {30'd0, bus.scanlines_o}, 32'h1);

    // Reset mid-operation: scanlines=2, ARMED, coin pulse active
    hotkey_cycle(2'd1);
    bus.start_n_i = 2'b00;
    ticks(40);
    chk("mid_armed", {31'd0, bus.hotkey_o}, 32'h1);
    ce_div = 4;
    phase  = 0;
    bus.kbd_i[15] = 1'b1;
    ticks(2);
    chk("mid_coin_active", {30'd0, bus.coin_o}, 32'h2);
    chk("mid_scan", {30'd0, bus.scanlines_o}, 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_coin", {30'd0, bus.coin_o}, 32'h0);
    chk("mid_rst_hotkey", {31'd0, bus.hotkey_o}, 32'h0);
    chk("mid_rst_scan", {30'd0, bus.scanlines_o}, 32'h0);
    chk("mid_rst_start", {30'd0, bus.start_o}, 32'h0);
    bus.start_n_i = 2'b11;
    bus.kbd_i     = 16'h0000;
    reset = 1'b0;
    ticks(120);
    chk("post_rst_scan", {30'd0, bus.scanlines_o}, 32'h0);
    chk("post_rst_hotkey", {31'd0, bus.hotkey_o}, 32'h0);
    chk("post_rst_coin", {30'd0, bus.coin_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
